// File: rtl/rename_unit_pkg.sv
// Shared constants and types for the register-rename stage.
// A physical tag is a free-list entry or a RAT entry. The architectural
// source bundle arrives from decode packed as {Src1, Src2, Rdst}.
package rename_unit_pkg;

   localparam int NUM_ARCH = 32;
   localparam int AREG_W   = 5;
   localparam int NUM_PHYS = 64;
   localparam int PTAG_W   = $clog2(NUM_PHYS);
   localparam int FL_DEPTH = NUM_PHYS - NUM_ARCH;
   localparam int FL_PTR_W = $clog2(FL_DEPTH);
   localparam int FL_CNT_W = FL_PTR_W + 1;

   typedef logic [PTAG_W-1:0] PTag;
   typedef logic [AREG_W-1:0] AReg;

   typedef struct packed {
      AReg Src1;
      AReg Src2;
      AReg Rdst;
   } Source;

   typedef struct packed {
      PTag PSrc1;
      PTag PSrc2;
      PTag PDst;
      PTag OldPDst;
   } Renamed;

   typedef struct packed {
      logic WrEn;
      AReg  Rdst;
      PTag  PDst;
      PTag  OldPDst;
   } Commit;

   // Free-list slot N starts out holding the first tag above the
   // architectural range, so identity RAT mappings never collide with it.
   function automatic PTag initFreeTag(input int slot);
      return PTag'(NUM_ARCH + slot);
   endfunction

endpackage

// File: rtl/rename_free_list.sv
// Circular FIFO of free physical tags. Pop hands out the head tag, push
// returns a committed instruction's old tag at the tail. Flush rolls head
// back to the post-push tail: the slots between tail and head still hold
// the squashed in-flight tags, so the whole ring becomes free again.
module rename_free_list
   import rename_unit_pkg::*;
(
   input  logic               Clk_i,
   input  logic               Rst_i,
   input  logic               Pop_i,
   input  logic               Push_i,
   input  logic [PTAG_W-1:0]  PushTag_i,
   input  logic               Flush_i,
   output logic [PTAG_W-1:0]  HeadTag_o,
   output logic               Empty_o
);

   PTag                 slotQ [FL_DEPTH];
   logic [FL_PTR_W-1:0] headQ, headD;
   logic [FL_PTR_W-1:0] tailQ, tailD;
   logic [FL_CNT_W-1:0] countQ, countD;

   assign HeadTag_o = slotQ[headQ];
   assign Empty_o   = (countQ == '0);

   // Pointer and occupancy next-state; a flush overrides pop and refills.
   always_comb begin
      headD  = headQ;
      tailD  = tailQ;
      countD = countQ;
      if (Push_i) begin
         tailD = tailQ + 1'b1;
      end
      if (Flush_i) begin
         headD  = tailD;
         countD = FL_CNT_W'(FL_DEPTH);
      end else begin
         if (Pop_i) begin
            headD = headQ + 1'b1;
         end
         case ({Pop_i, Push_i})
            2'b10:   countD = countQ - 1'b1;
            2'b01:   countD = countQ + 1'b1;
            default: countD = countQ;
         endcase
      end
   end

   // Ring storage and pointers; reset reloads the initial free tags.
   always_ff @(posedge Clk_i) begin
      if (!Rst_i) begin
         for (int i = 0; i < FL_DEPTH; i++) begin
            slotQ[i] <= initFreeTag(i);
         end
         headQ  <= '0;
         tailQ  <= '0;
         countQ <= FL_CNT_W'(FL_DEPTH);
      end else begin
         headQ  <= headD;
         tailQ  <= tailD;
         countQ <= countD;
         if (Push_i) begin
            slotQ[tailQ] <= PushTag_i;
         end
      end
   end

   OccupancyBound: assert property (@(posedge Clk_i) disable iff (!Rst_i)
      countQ <= FL_CNT_W'(FL_DEPTH));

   NoPushWhenFull: assert property (@(posedge Clk_i) disable iff (!Rst_i)
      !(Push_i && !Pop_i && countQ == FL_CNT_W'(FL_DEPTH)));

   NoPopWhenEmpty: assert property (@(posedge Clk_i) disable iff (!Rst_i)
      !(Pop_i && countQ == '0));

endmodule

// File: rtl/rename_unit.sv
// Single-issue rename stage. Maps source registers through the speculative
// RAT, allocates a fresh tag for a written destination, and reports the
// displaced tag for the ROB. Commits update the retirement RAT and free the
// old tag; a flush copies the retirement RAT back over the speculative one.
module rename_unit
   import rename_unit_pkg::*;
(
   input  logic               Clk_i,
   input  logic               Rst_i,
   input  logic               Flush_i,
   input  logic               Stall_i,
   input  logic               In_Valid_i,
   input  logic [14:0]        In_Src_i,
   input  logic               In_WrEn_i,
   output logic               In_Ready_o,
   output logic               Out_Valid_o,
   output logic [PTAG_W-1:0]  Out_PSrc1_o,
   output logic [PTAG_W-1:0]  Out_PSrc2_o,
   output logic [PTAG_W-1:0]  Out_PDst_o,
   output logic [PTAG_W-1:0]  Out_OldPDst_o,
   output logic               Out_WrEn_o,
   input  logic               Cmt_Valid_i,
   input  logic               Cmt_WrEn_i,
   input  logic [AREG_W-1:0]  Cmt_Rdst_i,
   input  logic [PTAG_W-1:0]  Cmt_PDst_i,
   input  logic [PTAG_W-1:0]  Cmt_OldPDst_i
);

   Source  src;
   Commit  cmt;
   PTag    specRatQ [NUM_ARCH];
   PTag    specRatD [NUM_ARCH];
   PTag    retRatQ  [NUM_ARCH];
   PTag    retRatD  [NUM_ARCH];
   Renamed outQ, outD;
   logic   outValidQ, outValidD;
   logic   outWrEnQ, outWrEnD;
   logic   accept, weff, alloc, cmtFire;
   logic   flEmpty;
   PTag    flHeadTag;

   assign src = In_Src_i;
   assign cmt = '{WrEn: Cmt_WrEn_i, Rdst: Cmt_Rdst_i, PDst: Cmt_PDst_i,
                  OldPDst: Cmt_OldPDst_i};

   // r0 is hardwired, so writes to it never consume a tag.
   assign In_Ready_o = !Stall_i && !Flush_i && !flEmpty;
   assign accept     = In_Valid_i && In_Ready_o;
   assign weff       = In_WrEn_i && (src.Rdst != '0);
   assign alloc      = accept && weff;
   assign cmtFire    = Cmt_Valid_i && cmt.WrEn && (cmt.Rdst != '0);

   rename_free_list u_freeList (
      .Clk_i     (Clk_i),
      .Rst_i     (Rst_i),
      .Pop_i     (alloc),
      .Push_i    (cmtFire),
      .PushTag_i (cmt.OldPDst),
      .Flush_i   (Flush_i),
      .HeadTag_o (flHeadTag),
      .Empty_o   (flEmpty)
   );

   // RAT next-state: the commit lands first so a flush inherits it.
   always_comb begin
      retRatD = retRatQ;
      if (cmtFire) begin
         retRatD[cmt.Rdst] = cmt.PDst;
      end
      specRatD = specRatQ;
      if (Flush_i) begin
         specRatD = retRatD;
      end else if (alloc) begin
         specRatD[src.Rdst] = flHeadTag;
      end
   end

   // Output register next-state: accept loads, stall holds, otherwise drain.
   always_comb begin
      outD      = outQ;
      outValidD = outValidQ;
      outWrEnD  = outWrEnQ;
      if (Flush_i) begin
         outValidD = 1'b0;
      end else if (accept) begin
         outD.PSrc1   = specRatQ[src.Src1];
         outD.PSrc2   = specRatQ[src.Src2];
         outD.PDst    = weff ? flHeadTag : '0;
         outD.OldPDst = weff ? specRatQ[src.Rdst] : '0;
         outValidD    = 1'b1;
         outWrEnD     = weff;
      end else if (!Stall_i) begin
         outValidD = 1'b0;
      end
   end

   // State registers; reset restores identity mappings and clears outputs.
   always_ff @(posedge Clk_i) begin
      if (!Rst_i) begin
         for (int i = 0; i < NUM_ARCH; i++) begin
            specRatQ[i] <= PTag'(i);
            retRatQ[i]  <= PTag'(i);
         end
         outQ      <= '0;
         outValidQ <= 1'b0;
         outWrEnQ  <= 1'b0;
      end else begin
         specRatQ  <= specRatD;
         retRatQ   <= retRatD;
         outQ      <= outD;
         outValidQ <= outValidD;
         outWrEnQ  <= outWrEnD;
      end
   end

   assign Out_Valid_o   = outValidQ;
   assign Out_WrEn_o    = outWrEnQ;
   assign Out_PSrc1_o   = outQ.PSrc1;
   assign Out_PSrc2_o   = outQ.PSrc2;
   assign Out_PDst_o    = outQ.PDst;
   assign Out_OldPDst_o = outQ.OldPDst;

endmodule

// File: tb/tb_rename_unit.sv
// Bench for rename_unit: a queue-based rename model tracked at every clock,
// a negedge comparator, and directed scenarios with literal expectations.
module tb_rename_unit;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Flush, Stall, In_Valid, In_WrEn, In_Ready;
   logic [14:0] In_Src;
   logic        Out_Valid, Out_WrEn;
   logic [5:0]  Out_PSrc1, Out_PSrc2, Out_PDst, Out_OldPDst;
   logic        Cmt_Valid, Cmt_WrEn;
   logic [4:0]  Cmt_Rdst;
   logic [5:0]  Cmt_PDst, Cmt_OldPDst;

   int checks = 0;
   int errors = 0;

   // Model state: architectural maps, ordered free tags, in-flight tags.
   int specRat [32];
   int retRat  [32];
   int freeQ   [$];
   int inflQ   [$];
   bit expValid, expWrEn;
   int expPSrc1, expPSrc2, expPDst, expOld;
   bit checkEn = 1'b0;

   bit mReady, mAccept, mWeff, mCommit;
   int mS1, mS2, mRd, mTag;

   always #5 Clk = ~Clk;

   rename_unit dut (
      .Clk_i         (Clk),
      .Rst_i         (Rst),
      .Flush_i       (Flush),
      .Stall_i       (Stall),
      .In_Valid_i    (In_Valid),
      .In_Src_i      (In_Src),
      .In_WrEn_i     (In_WrEn),
      .In_Ready_o    (In_Ready),
      .Out_Valid_o   (Out_Valid),
      .Out_PSrc1_o   (Out_PSrc1),
      .Out_PSrc2_o   (Out_PSrc2),
      .Out_PDst_o    (Out_PDst),
      .Out_OldPDst_o (Out_OldPDst),
      .Out_WrEn_o    (Out_WrEn),
      .Cmt_Valid_i   (Cmt_Valid),
      .Cmt_WrEn_i    (Cmt_WrEn),
      .Cmt_Rdst_i    (Cmt_Rdst),
      .Cmt_PDst_i    (Cmt_PDst),
      .Cmt_OldPDst_i (Cmt_OldPDst)
   );

   task automatic cmp(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      freeQ.delete();
      inflQ.delete();
      for (int i = 0; i < 32; i++) begin
         specRat[i] = i;
         retRat[i]  = i;
         freeQ.push_back(32 + i);
      end
      expValid = 0; expWrEn = 0;
      expPSrc1 = 0; expPSrc2 = 0; expPDst = 0; expOld = 0;
   endtask

   // Model advances on each rising edge using the inputs held over that edge.
   always @(posedge Clk) begin
      if (!Rst) begin
         modelReset();
      end else begin
         mS1 = int'(In_Src[14:10]);
         mS2 = int'(In_Src[9:5]);
         mRd = int'(In_Src[4:0]);
         mReady  = !Stall && !Flush && (freeQ.size() != 0);
         mAccept = In_Valid && mReady;
         mWeff   = In_WrEn && (mRd != 0);
         mCommit = Cmt_Valid && Cmt_WrEn && (Cmt_Rdst != 0);
         if (mAccept) begin
            expPSrc1 = specRat[mS1];
            expPSrc2 = specRat[mS2];
            if (mWeff) begin
               mTag = freeQ.pop_front();
               expPDst = mTag;
               expOld  = specRat[mRd];
               specRat[mRd] = mTag;
               inflQ.push_back(mTag);
            end else begin
               expPDst = 0;
               expOld  = 0;
            end
            expWrEn  = mWeff;
            expValid = 1;
         end else if (Flush || !Stall) begin
            expValid = 0;
         end
         if (mCommit) begin
            retRat[Cmt_Rdst] = int'(Cmt_PDst);
            freeQ.push_back(int'(Cmt_OldPDst));
            if (inflQ.size() > 0) void'(inflQ.pop_front());
         end
         if (Flush) begin
            specRat = retRat;
            freeQ = {inflQ, freeQ};
            inflQ.delete();
         end
      end
   end

   // Mid-cycle comparison of the DUT against the model.
   always @(negedge Clk) begin
      if (checkEn) begin
         cmp("model.In_Ready", int'(In_Ready),
             int'(!Stall && !Flush && (freeQ.size() != 0)));
         cmp("model.Out_Valid", int'(Out_Valid), int'(expValid));
         if (expValid) begin
            cmp("model.Out_PSrc1", int'(Out_PSrc1), expPSrc1);
            cmp("model.Out_PSrc2", int'(Out_PSrc2), expPSrc2);
            cmp("model.Out_PDst", int'(Out_PDst), expPDst);
            cmp("model.Out_OldPDst", int'(Out_OldPDst), expOld);
            cmp("model.Out_WrEn", int'(Out_WrEn), int'(expWrEn));
         end
      end
   end

   task automatic applyStimulus(input bit v, input int s1, input int s2, input int rd,
                                input bit wr, input bit stall, input bit flush,
                                input bit cv, input int crd, input int cpd, input int cold);
      In_Valid    = v;
      In_Src      = {5'(s1), 5'(s2), 5'(rd)};
      In_WrEn     = wr;
      Stall       = stall;
      Flush       = flush;
      Cmt_Valid   = cv;
      Cmt_WrEn    = cv;
      Cmt_Rdst    = 5'(crd);
      Cmt_PDst    = 6'(cpd);
      Cmt_OldPDst = 6'(cold);
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic rename(input int s1, input int s2, input int rd);
      applyStimulus(1, s1, s2, rd, 1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic checkOutput(input string name, input bit v, input int p1, input int p2,
                              input int pd, input int old, input bit wr);
      cmp({name, ".Valid"}, int'(Out_Valid), int'(v));
      cmp({name, ".PSrc1"}, int'(Out_PSrc1), p1);
      cmp({name, ".PSrc2"}, int'(Out_PSrc2), p2);
      cmp({name, ".PDst"}, int'(Out_PDst), pd);
      cmp({name, ".OldPDst"}, int'(Out_OldPDst), old);
      cmp({name, ".WrEn"}, int'(Out_WrEn), int'(wr));
   endtask

   task automatic doReset();
      Rst = 1'b0;
      idle();
      Rst = 1'b1;
   endtask

   initial begin
      Rst = 1'b0;
      In_Valid = 0; In_Src = '0; In_WrEn = 0; Stall = 0; Flush = 0;
      Cmt_Valid = 0; Cmt_WrEn = 0; Cmt_Rdst = '0; Cmt_PDst = '0; Cmt_OldPDst = '0;
      repeat (2) @(posedge Clk);
      #1;
      checkEn = 1'b1;
      checkOutput("reset", 0, 0, 0, 0, 0, 0);
      cmp("reset.In_Ready", int'(In_Ready), 1);
      Rst = 1'b1;

      $display("[TB] basic rename and r0 handling");
      rename(1, 2, 0);
      checkOutput("r0", 1, 1, 2, 0, 0, 0);
      rename(3, 4, 5);
      checkOutput("first", 1, 3, 4, 32, 5, 1);
      rename(5, 5, 6);
      checkOutput("dep", 1, 32, 32, 33, 6, 1);
      rename(6, 0, 6);
      checkOutput("selfRead", 1, 33, 0, 34, 33, 1);
      idle();
      cmp("idle.Valid", int'(Out_Valid), 0);

      $display("[TB] free list exhaustion");
      doReset();
      for (int i = 0; i < 32; i++) begin
         rename(0, 0, (i == 0) ? 5 : (i % 31) + 1);
      end
      cmp("full.lastPDst", int'(Out_PDst), 63);
      cmp("full.In_Ready", int'(In_Ready), 0);
      rename(0, 0, 9);
      cmp("full.noAccept", int'(Out_Valid), 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5, 32, 5);
      cmp("freed.In_Ready", int'(In_Ready), 1);
      rename(0, 0, 9);
      checkOutput("afterFree", 1, 0, 0, 5, 40, 1);

      $display("[TB] flush with same-cycle commit");
      doReset();
      rename(0, 0, 1);
      rename(0, 0, 2);
      rename(0, 0, 3);
      checkOutput("r3", 1, 0, 0, 34, 3, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1, 32, 1);
      cmp("flush.Valid", int'(Out_Valid), 0);
      rename(1, 2, 4);
      checkOutput("flushRead", 1, 32, 2, 33, 4, 1);

      $display("[TB] stall hold and release");
      rename(4, 1, 10);
      checkOutput("stallA", 1, 33, 32, 34, 10, 1);
      for (int k = 0; k < 3; k++) begin
         if (k == 1) applyStimulus(1, 10, 0, 11, 1, 1, 0, 1, 4, 33, 4);
         else        applyStimulus(1, 10, 0, 11, 1, 1, 0, 0, 0, 0, 0);
         cmp("stall.In_Ready", int'(In_Ready), 0);
         checkOutput("stallHold", 1, 33, 32, 34, 10, 1);
      end
      applyStimulus(1, 10, 0, 11, 1, 0, 0, 1, 10, 34, 10);
      checkOutput("release", 1, 34, 0, 35, 11, 1);
      idle();
      cmp("releaseOnce.Valid", int'(Out_Valid), 0);

      $display("[TB] reset mid-stream");
      doReset();
      for (int i = 0; i < 10; i++) rename(0, 0, i + 1);
      Rst = 1'b0;
      rename(0, 0, 12);
      checkOutput("midReset", 0, 0, 0, 0, 0, 0);
      Rst = 1'b1;
      rename(1, 2, 3);
      checkOutput("postReset", 1, 1, 2, 32, 3, 1);
      idle();

      checkEn = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
